my_cmd_decoder: RTL
===================

# my_cmd_decoder

Byte-level command framer that sits directly downstream of the UART receiver in the logic-analyzer front end. It consumes the receiver's `DataOut`/`DataReady` pair, locates a sync byte and assembles a fixed-length command frame (command, 16-bit argument, optional checksum). It then presents the decoded command to the capture/trigger control logic as a single-cycle strobe. Malformed or stalled frames are dropped and flagged.

## Interface
- `SYNC_BYTE`, default 8'hAA: frame start marker.
- `TIMEOUT`, default 40000: maximum idle clock cycles between bytes inside a frame.
- `TOUT_W`, default 16: width of the inter-byte timeout counter; must satisfy 2^TOUT_W > TIMEOUT.

- `CLKP4`, input, 1: clock; the same 4x-baud clock that drives the receiver.
- `RSTn`, input, 1: reset; asynchronous, active-low.
- `EN`, input, 1: decoder enable.
- `DataOut`, input, 8: received byte from the UART receiver.
- `DataReady`, input, 1: byte-ready level from the receiver; stays high for several cycles per byte.
- `Cmd`, output, 8: last valid command byte.
- `Arg`, output, 16: last valid argument, {ArgH, ArgL}.
- `CmdValid`, output, 1: one-cycle strobe when a new `Cmd`/`Arg` is loaded.
- `CmdError`, output, 1: one-cycle strobe on checksum mismatch or timeout.
- `Busy`, output, 1: high while a frame is in progress (state ≠ IDLE).

## Operation
- Byte strobe: `DrPrev` is registered from `DataReady`. `ByteStb = DataReady & ~DrPrev`.
  - Exactly one strobe per received byte, regardless of how long `DataReady` stays high.
  - `DataOut` is sampled on the clock edge where `ByteStb` = 1.
- FSM states: IDLE → CMD → ARGL → ARGH → CHK → IDLE. Transitions happen only on `ByteStb`, except for timeout.
  - IDLE: byte == `SYNC_BYTE` → CMD. Any other byte is ignored silently, with no error.
  - CMD: store byte as `CmdReg` → ARGL.
  - ARGL: store `ArgL` → ARGH.
  - ARGH: store `ArgH` → CHK.
  - CHK: compare byte against `CmdReg ^ ArgL ^ ArgH`.
    - Match: load `Cmd`/`Arg` and pulse `CmdValid`.
    - Mismatch: pulse `CmdError`; `Cmd`/`Arg` are unchanged.
    - Either way → IDLE.
- Any byte value, including `SYNC_BYTE`, is accepted as data in CMD, ARGL, ARGH and CHK. There is no resynchronisation mid-frame.
- Timeout counter:
  - Cleared on every `ByteStb` and whenever in IDLE; otherwise increments by 1 per cycle.
  - When it reaches `TIMEOUT-1` outside IDLE: go to IDLE and pulse `CmdError`.
- Simultaneous `ByteStb` and timeout terminal count: the byte wins. The counter clears and no error is raised.
- `EN` = 0:
  - FSM forced to IDLE, counter cleared, no strobes.
  - `DrPrev` still tracks `DataReady`, so a byte already in flight does not generate a spurious strobe when `EN` rises.
  - `Cmd`/`Arg` hold their values.

## Timing
- Reset values: `Cmd` = 0, `Arg` = 0, `CmdValid` = 0, `CmdError` = 0, `Busy` = 0, FSM = IDLE, `DrPrev` = 0, counter = 0.
- Latency: `CmdValid`/`CmdError` go high on the first clock edge after the cycle in which `ByteStb` of the final byte is high. They last exactly 1 cycle.
- `Cmd`/`Arg` change only on that same edge and are stable while `CmdValid` = 1 and afterwards.
- `Busy` rises on the edge that accepts the sync byte. It falls on the edge that returns the FSM to IDLE.
- Asynchronous reset mid-frame: the partial frame is discarded and no strobe is emitted.
- After reset deassertion, a `DataReady` that is already high produces a strobe, because `DrPrev` resets to 0.

## Configuration
- `MY_CMD_CHECKSUM_EN` defined:
  - 5-byte frame (sync, cmd, argL, argH, chk) with the CHK state present.
  - `CmdError` on mismatch or timeout.
- Not defined:
  - 4-byte frame; the CHK state is not compiled.
  - The `ByteStb` in ARGH loads `Cmd`/`Arg` and pulses `CmdValid` one edge later, then → IDLE.
  - `CmdError` fires only on timeout.

## Test plan
- Checksum on: bytes AA 12 34 56 70 → one `CmdValid` cycle; `Cmd` = 8'h12, `Arg` = 16'h5634; `CmdError` never high.
- Bytes AA 12 34 56 71 → one `CmdError` pulse, no `CmdValid`; `Cmd`/`Arg` keep their prior values; `Busy` = 0 afterwards.
- Bytes 00 FF 55 then AA 01 00 00 01 → leading garbage ignored with no error; one `CmdValid`, `Cmd` = 8'h01, `Arg` = 16'h0000.
- `TIMEOUT` = 100: send AA 12, then idle 200 cycles → `CmdError` exactly 100 cycles after the 12 strobe; `Busy` drops the same edge. A following full valid frame decodes normally.
- `DataReady` held high for 10 cycles per byte, and separately for 1 cycle per byte → identical single strobe per byte and identical decode of AA 12 34 56 70.
- `RSTn` pulsed low after AA 12 34, and `EN` dropped mid-frame in a separate run → no strobes; `Busy` = 0, outputs at reset/hold values. A following valid frame decodes.

Source files
------------

// File: rtl/my_cmd_decoder_if.sv
// my_cmd_decoder_if: byte input and decoded command output of the command framer.
//   DataOut/DataReady : byte and byte-ready level from the UART receiver
//   Cmd/Arg           : last valid command byte and 16-bit argument
//   CmdValid/CmdError : one-cycle strobes for a decoded frame / a dropped frame
//   Busy              : frame in progress
// master: receiver + capture control side; slave: the decoder.
interface my_cmd_decoder_if;
    logic [7:0]  DataOut;
    logic        DataReady;
    logic [7:0]  Cmd;
    logic [15:0] Arg;
    logic        CmdValid;
    logic        CmdError;
    logic        Busy;

    modport master (
        output DataOut,
        output DataReady,
        input  Cmd,
        input  Arg,
        input  CmdValid,
        input  CmdError,
        input  Busy
    );

    modport slave (
        input  DataOut,
        input  DataReady,
        output Cmd,
        output Arg,
        output CmdValid,
        output CmdError,
        output Busy
    );
endinterface

// File: rtl/my_cmd_decoder.sv
// my_cmd_decoder: locates a sync byte in the UART byte stream and assembles a
// fixed-length command frame (cmd, argL, argH[, chk]), presenting the result as
// a one-cycle CmdValid strobe. Stalled frames (and bad checksums) raise CmdError.
//   CLKP4 : 4x-baud clock shared with the receiver
//   RSTn  : asynchronous active-low reset
//   EN    : decoder enable; low forces IDLE and holds Cmd/Arg
//   bus   : my_cmd_decoder_if.slave (DataOut/DataReady in, Cmd/Arg/strobes/Busy out)
// Build option: define MY_CMD_CHECKSUM_EN for the 5-byte frame with checksum.
module my_cmd_decoder #(
    parameter logic [7:0]  SYNC_BYTE = 8'hAA,
    parameter int unsigned TIMEOUT   = 40000,
    parameter int unsigned TOUT_W    = 16
) (
    input  logic             CLKP4,
    input  logic             RSTn,
    input  logic             EN,
    my_cmd_decoder_if.slave  bus
);

    localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT - 1);

`ifdef MY_CMD_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ARGL = 3'd2,
        S_ARGH = 3'd3,
        S_CHK  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ARGL = 3'd2,
        S_ARGH = 3'd3
    } state_t;
`endif

    state_t            state_q, state_d;
    logic              dr_prev_q;
    logic [TOUT_W-1:0] cnt_q, cnt_d;
    logic [7:0]        cmd_reg_q, cmd_reg_d;
    logic [7:0]        argl_q, argl_d;
`ifdef MY_CMD_CHECKSUM_EN
    logic [7:0]        argh_q, argh_d;
`endif
    logic [7:0]        cmd_q, cmd_d;
    logic [15:0]       arg_q, arg_d;
    logic              valid_q, valid_d;
    logic              error_q, error_d;
    logic              busy_q, busy_d;
    logic              byte_stb;
    logic              tout_hit;

    // One strobe per byte: rising edge of the receiver's ready level.
    assign byte_stb = bus.DataReady & ~dr_prev_q;
    assign tout_hit = (cnt_q == TOUT_LAST);

    // State and data registers.
    always_ff @(posedge CLKP4 or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= S_IDLE;
            dr_prev_q <= 1'b0;
            cnt_q     <= '0;
            cmd_reg_q <= 8'h00;
            argl_q    <= 8'h00;
`ifdef MY_CMD_CHECKSUM_EN
            argh_q    <= 8'h00;
`endif
            cmd_q     <= 8'h00;
            arg_q     <= 16'h0000;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            // Tracks DataReady even when disabled so EN rising mid-byte is silent.
            dr_prev_q <= bus.DataReady;
            cnt_q     <= cnt_d;
            cmd_reg_q <= cmd_reg_d;
            argl_q    <= argl_d;
`ifdef MY_CMD_CHECKSUM_EN
            argh_q    <= argh_d;
`endif
            cmd_q     <= cmd_d;
            arg_q     <= arg_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state, frame assembly and strobe generation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + TOUT_W'(1);
        cmd_reg_d = cmd_reg_q;
        argl_d    = argl_q;
`ifdef MY_CMD_CHECKSUM_EN
        argh_d    = argh_q;
`endif
        cmd_d     = cmd_q;
        arg_d     = arg_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;

        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end

        if (!EN) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (byte_stb) begin
            // A byte arriving on the terminal count still wins over the timeout.
            cnt_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (bus.DataOut == SYNC_BYTE) begin
                        state_d = S_CMD;
                    end
                end
                S_CMD: begin
                    cmd_reg_d = bus.DataOut;
                    state_d   = S_ARGL;
                end
                S_ARGL: begin
                    argl_d  = bus.DataOut;
                    state_d = S_ARGH;
                end
`ifdef MY_CMD_CHECKSUM_EN
                S_ARGH: begin
                    argh_d  = bus.DataOut;
                    state_d = S_CHK;
                end
                S_CHK: begin
                    if (bus.DataOut == (cmd_reg_q ^ argl_q ^ argh_q)) begin
                        cmd_d   = cmd_reg_q;
                        arg_d   = {argh_q, argl_q};
                        valid_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
`else
                S_ARGH: begin
                    cmd_d   = cmd_reg_q;
                    arg_d   = {bus.DataOut, argl_q};
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end
`endif
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else if ((state_q != S_IDLE) && tout_hit) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            error_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign bus.Cmd      = cmd_q;
    assign bus.Arg      = arg_q;
    assign bus.CmdValid = valid_q;
    assign bus.CmdError = error_q;
    assign bus.Busy     = busy_q;

endmodule
